// File: rtl/jtpopeye_rom_pkg.sv
// jtpopeye_rom_pkg: shared FSM states and SDRAM widths for the Popeye ROM arbiter
package jtpopeye_rom_pkg;
  localparam int SDRAM_AW = 22;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
endpackage

// File: rtl/jtpopeye_rom_slot.sv
// jtpopeye_rom_slot: one-word cache per ROM client (tag, valid, word, hit compare, byte select)
module jtpopeye_rom_slot
  import jtpopeye_rom_pkg::*;
#(
  parameter int SLOT_AW = 16,
  parameter logic [22:0] OFFSET = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                cs,
  input  logic [SLOT_AW-1:0]  addr,
  input  logic                we,
  input  logic [SDRAM_AW-2:0] wtag,
  input  logic [WORD_W-1:0]   wdata,
  output logic [22:0]         full,
  output logic                pending,
  output logic                ok,
  output logic [7:0]          dout
);
  logic                valid;
  logic [SDRAM_AW-2:0] tag;
  logic [WORD_W-1:0]   word;
  logic                hit;
  assign full = OFFSET + 23'(addr);
  assign hit = cs & valid & (tag == full[22:2]);
  assign pending = cs & ~hit;
  // store fetched word on write strobe; clr drops the cached word while the loop restarts
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      word  <= '0;
      ok    <= 1'b0;
      dout  <= '0;
    end else begin
      valid <= clr ? 1'b0 : (we ? 1'b1 : valid);
      if (we) begin
        tag  <= wtag;
        word <= wdata;
      end
      ok   <= hit & ~clr;
      dout <= word[{full[1:0], 3'b000} +: 8];
    end
endmodule

// File: rtl/jtpopeye_rom_arb.sv
// jtpopeye_rom_arb: multiplexes byte-wide ROM clients onto one 32-bit SDRAM read channel.
// Define ROMARB_RR_EN for round-robin arbitration; otherwise the lowest slot index wins.
module jtpopeye_rom_arb
  import jtpopeye_rom_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int SLOT_AW = 16,
  parameter logic [23*SLOTS-1:0] OFFSETS = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     downloading,
  input  logic [SLOTS*SLOT_AW-1:0] slot_addr,
  input  logic [SLOTS-1:0]         slot_cs,
  output logic [SLOTS-1:0]         slot_ok,
  output logic [SLOTS*8-1:0]       slot_dout,
  output logic                     loop_rst,
  output logic [SDRAM_AW-1:0]      sdram_addr,
  output logic                     sdram_req,
  input  logic                     sdram_ack,
  input  logic [WORD_W-1:0]        data_read,
  input  logic                     data_rdy,
  output logic                     refresh_en
);
  localparam int IW = SLOTS > 1 ? $clog2(SLOTS) : 1;
  state_t         st;
  logic [IW-1:0]  win, win_q;
  logic [SLOTS-1:0] pending;
  logic [22:0]    full [SLOTS];
  logic           we;
  int             j;
  assign we = (st == WAIT) & data_rdy & ~loop_rst;
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    jtpopeye_rom_slot #(.SLOT_AW(SLOT_AW), .OFFSET(OFFSETS[23*i +: 23])) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (loop_rst),
      .cs      (slot_cs[i]),
      .addr    (slot_addr[SLOT_AW*i +: SLOT_AW]),
      .we      (we & (win_q == IW'(i))),
      .wtag    (sdram_addr[SDRAM_AW-1:1]),
      .wdata   (data_read),
      .full    (full[i]),
      .pending (pending[i]),
      .ok      (slot_ok[i]),
      .dout    (slot_dout[8*i +: 8])
    );
  end
`ifdef ROMARB_RR_EN
  logic [IW-1:0] last;
  // remember the last granted slot so the search starts right after it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= IW'(SLOTS-1);
    else if (st == IDLE && !loop_rst && |pending) last <= win;
`endif
  // scan from lowest to highest priority so the highest-priority pending slot is assigned last
  always_comb begin
    win = '0;
    j = 0;
    for (int k = SLOTS-1; k >= 0; k--) begin
`ifdef ROMARB_RR_EN
      j = (int'(last) + 1 + k) % SLOTS;
`else
      j = k;
`endif
      if (pending[j]) win = IW'(j);
    end
  end
  // request FSM: one SDRAM fetch at a time, aborted whenever the loop restarts
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st         <= IDLE;
      win_q      <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      refresh_en <= 1'b0;
      loop_rst   <= 1'b1;
    end else begin
      loop_rst   <= downloading;
      refresh_en <= (st == IDLE) & ~|pending & ~loop_rst;
      if (loop_rst) begin
        st        <= IDLE;
        sdram_req <= 1'b0;
      end else begin
        case (st)
          IDLE: if (|pending) begin
            win_q      <= win;
            sdram_addr <= {full[win][22:2], 1'b0};
            sdram_req  <= 1'b1;
            st         <= REQ;
          end
          REQ: if (sdram_ack) begin
            sdram_req <= 1'b0;
            st        <= WAIT;
          end
          WAIT: if (data_rdy) st <= IDLE;
          default: st <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_jtpopeye_rom_arb.sv
// tb_jtpopeye_rom_arb: directed and randomized checks of the ROM arbiter against a ROM model
`timescale 1ns/1ps
module tb_jtpopeye_rom_arb;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        downloading = 0;
  logic [63:0] sa = '0;
  logic [3:0]  cs = '0;
  logic [3:0]  slot_ok;
  logic [31:0] slot_dout;
  logic        loop_rst;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        ack = 0;
  logic [31:0] data = '0;
  logic        rdy = 0;
  logic        refresh_en;
  int ncmp = 0, nbad = 0;
  bit mon_en = 0, slow = 0;
  logic [21:0] reqlog [$];
  logic [63:0] addr_q;
  logic [3:0]  cs_q;
  int unsigned cnt [4];
  localparam logic [91:0] OFFS = {23'h7FFFF0, 23'h100000, 23'h008000, 23'h000000};

  jtpopeye_rom_arb #(.SLOTS(4), .SLOT_AW(16), .OFFSETS(OFFS)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .slot_addr(sa), .slot_cs(cs),
    .slot_ok(slot_ok), .slot_dout(slot_dout), .loop_rst(loop_rst), .sdram_addr(sdram_addr),
    .sdram_req(sdram_req), .sdram_ack(ack), .data_read(data), .data_rdy(rdy), .refresh_en(refresh_en)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(int unsigned w);
    return w == 1 ? 32'h44332211 : (w * 32'h9E3779B1) ^ 32'hA5A50000 ^ w;
  endfunction

  function automatic logic [7:0] exp_byte(int i, logic [15:0] a);
    logic [91:0]  o = OFFS;
    int unsigned f = (int'(o[23*i +: 23]) + int'(a)) & 32'h7FFFFF;
    logic [31:0]  w = memf(f >> 2);
    return w[8*(f & 3) +: 8];
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ok(int i, string tag);
    int n = 0;
    while (!slot_ok[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(slot_ok[i]), 1);
  endtask

  task automatic wait_mask(logic [3:0] m, string tag);
    int n = 0;
    while ((slot_ok & m) != m && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(slot_ok & m), 32'(m));
  endtask

  // SDRAM frame model: acks after a random delay, returns ROM word from the requested address
  initial begin
    logic [21:0] a;
    forever begin
      @(negedge clk);
      if (sdram_req) begin
        a = sdram_addr;
        reqlog.push_back(a);
        chk("addr_lsb", 32'(sdram_addr[0]), 0);
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          chk("req_hold", {9'd0, sdram_req, sdram_addr}, {9'd0, 1'b1, a});
        end
        ack = 1;
        @(negedge clk);
        ack = 0;
        repeat (slow ? 6 : $urandom_range(0, 3)) @(negedge clk);
        data = memf(32'(a[21:1]));
        rdy = 1;
        @(negedge clk);
        rdy = 0;
        data = $urandom;
      end
    end
  end

  always @(posedge clk) begin
    addr_q <= sa;
    cs_q <= cs;
  end

  // every served byte must match the ROM model at the address presented on the previous edge
  always @(negedge clk)
    if (mon_en)
      for (int i = 0; i < 4; i++)
        if (!cs_q[i]) chk("ok_no_cs", 32'(slot_ok[i]), 0);
        else if (slot_ok[i]) chk("dout", 32'(slot_dout[8*i +: 8]), 32'(exp_byte(i, addr_q[16*i +: 16])));

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int r;
    tick(3);
    chk("rst_ok", 32'(slot_ok), 0);
    chk("rst_dout", slot_dout, 0);
    chk("rst_req", 32'(sdram_req), 0);
    chk("rst_addr", 32'(sdram_addr), 0);
    chk("rst_refresh", 32'(refresh_en), 0);
    chk("rst_loop", 32'(loop_rst), 1);
    rst_n = 1;
    mon_en = 1;
    tick(3);
    chk("loop_low", 32'(loop_rst), 0);
    chk("refresh_idle", 32'(refresh_en), 1);
    // first fetch: byte 5 lives in word 1, lane 1
    cs[0] = 1;
    sa[15:0] = 16'h0005;
    tick(1);
    chk("req_lat", 32'(sdram_req), 1);
    chk("req_addr", 32'(sdram_addr), 32'h2);
    chk("refresh_miss", 32'(refresh_en), 0);
    wait_ok(0, "ok0_first");
    chk("dout0_first", 32'(slot_dout[7:0]), 32'h22);
    // same word, different lane: served from the stored word
    sa[15:0] = 16'h0006;
    reqlog.delete();
    tick(1);
    chk("same_word_ok", 32'(slot_ok[0]), 1);
    chk("same_word_dout", 32'(slot_dout[7:0]), 32'h33);
    tick(2);
    chk("same_word_noreq", 32'(reqlog.size()), 0);
    // slots 0 and 2 miss together
    reqlog.delete();
    sa[15:0] = 16'h0100;
    sa[47:32] = 16'h0200;
    cs[2] = 1;
    wait_mask(4'b0101, "both_served");
    chk("both_nreq", 32'(reqlog.size()), 2);
    if (reqlog.size() >= 2) begin
`ifdef ROMARB_RR_EN
      chk("order_first", 32'(reqlog[0]), 32'h080100);
      chk("order_second", 32'(reqlog[1]), 32'h000080);
`else
      chk("order_first", 32'(reqlog[0]), 32'h000080);
      chk("order_second", 32'(reqlog[1]), 32'h080100);
`endif
    end
    // slot 1 with base offset 0x8000, lane 3
    reqlog.delete();
    cs[1] = 1;
    sa[31:16] = 16'h0003;
    wait_ok(1, "ok1");
    chk("dout1_lane3", 32'(slot_dout[15:8]), 32'(memf(32'h2000) >> 24));
    if (reqlog.size() >= 1) chk("slot1_addr", 32'(reqlog[0]), 32'h004000);
    else chk("slot1_nreq", 32'(reqlog.size()), 1);
    // refresh window
    cs = '0;
    tick(2);
    chk("refresh_nocs", 32'(refresh_en), 1);
    cs[0] = 1;
    sa[15:0] = 16'h0300;
    tick(1);
    chk("refresh_drop", 32'(refresh_en), 0);
    wait_ok(0, "ok0_after_refresh");
    // download aborts a fetch in WAIT and invalidates all slots
    slow = 1;
    cs[2] = 1;
    sa[15:0] = 16'h0400;
    reqlog.delete();
    n = 0;
    while (!sdram_req && n < 50) begin tick(1); n++; end
    while (sdram_req && n < 100) begin tick(1); n++; end
    chk("dl_setup", 32'(n < 100), 1);
    downloading = 1;
    tick(1);
    chk("dl_loop", 32'(loop_rst), 1);
    chk("dl_req", 32'(sdram_req), 0);
    tick(8);
    chk("dl_ok", 32'(slot_ok), 0);
    chk("dl_req_hold", 32'(sdram_req), 0);
    chk("dl_refresh", 32'(refresh_en), 0);
    chk("dl_nreq", 32'(reqlog.size()), 1);
    downloading = 0;
    slow = 0;
    wait_mask(4'b0101, "dl_recover");
    chk("dl_refetch", 32'(reqlog.size()), 3);
    // randomized traffic with liveness check on stable requests
    foreach (cnt[i]) cnt[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 199);
        if (r == 0) begin
          cs[i] = ~cs[i];
          cnt[i] = 0;
        end else if (r == 1) begin
          sa[16*i +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
          cnt[i] = 0;
        end else if (cs[i]) begin
          cnt[i]++;
          if (cnt[i] == 200) chk("live", 32'(slot_ok[i]), 1);
        end
      end
    end
    cs = '0;
    tick(20);
    chk("final_refresh", 32'(refresh_en), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
